memory_access_unit: RTL and testbench

//  Memory stage downstream of the execute pipeline register. Consumes the registered

---
 rtl/memory_access_unit_if.sv | 23 ++
 rtl/memory_access_unit.sv | 140 ++++++++++++++
 tb/tb_memory_access_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory port of the memory stage: one request at a time on a req/ready handshake.
// The master (memory_access_unit) drives the request side; the memory answers with ready/rdata.
interface memory_access_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [DATA_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_o;
    logic                    mem_ready_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage: issues one aligned load/store per instruction, lane-aligns store data,
// extracts/extends load data and stalls upstream until the access completes or times out.
module memory_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resultSRCE_i,
    input  logic                  memWriteE_i,
    input  logic [DATA_WIDTH-1:0] ALUresultE_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [1:0]            memTypeE_i,
    input  logic                  memSignE_i,
    memory_access_unit_if.master  mem,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] readDataM_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  timeout_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic                  we_q;
    logic [1:0]            type_q;
    logic [1:0]            off_q;
    logic                  sign_q;
    logic                  timeout_q;

    logic                  access;
    logic                  misalign;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [3:0]            lane_wstrb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign access   = resultSRCE_i | memWriteE_i;
    assign misalign = ((memTypeE_i == 2'b01) && ALUresultE_i[0]) ||
                      (memTypeE_i[1] && (ALUresultE_i[1:0] != 2'b00));

    assign stall_o      = ((state == IDLE) && access && !misalign) || (state == REQ);
    assign misaligned_o = (state == IDLE) && access && misalign;
    assign done_o       = (state == DONE);
    assign timeout_o    = timeout_q;

    assign mem.mem_req_o   = (state == REQ);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_wstrb_o = wstrb_q;

    always_comb begin
        lane_wdata = RD2E_i;
        lane_wstrb = 4'b1111;
        case (memTypeE_i)
            2'b00: begin
                lane_wdata = {4{RD2E_i[7:0]}};
                lane_wstrb = 4'b0001 << ALUresultE_i[1:0];
            end
            2'b01: begin
                lane_wdata = {2{RD2E_i[15:0]}};
                lane_wstrb = 4'b0011 << ALUresultE_i[1:0];
            end
            default: ;
        endcase
    end

    // Extraction uses the latched offset/type, since the pipeline inputs may move on.
    always_comb begin
        ld_byte  = mem.mem_rdata_i[{off_q, 3'b000} +: 8];
        ld_half  = mem.mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        load_ext = mem.mem_rdata_i;
        case (type_q)
            2'b00:   load_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            type_q      <= 2'b00;
            off_q       <= 2'b00;
            sign_q      <= 1'b0;
            timeout_q   <= 1'b0;
            readDataM_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (access && !misalign) begin
                        addr_q   <= {ALUresultE_i[DATA_WIDTH-1:2], 2'b00};
                        wdata_q  <= lane_wdata;
                        wstrb_q  <= memWriteE_i ? lane_wstrb : 4'b0000;
                        we_q     <= memWriteE_i;
                        type_q   <= memTypeE_i;
                        off_q    <= ALUresultE_i[1:0];
                        sign_q   <= memSignE_i;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ready_i) begin
                        if (!we_q) readDataM_o <= load_ext;
                        state <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        if (!we_q) readDataM_o <= '0;
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: expected transactions are queued when driven
// and checked when the unit signals completion; a small memory responder lives in the tasks.
module tb_memory_access_unit;
    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        resultSRCE_i;
    logic        memWriteE_i;
    logic [31:0] ALUresultE_i;
    logic [31:0] RD2E_i;
    logic [1:0]  memTypeE_i;
    logic        memSignE_i;
    logic        stall_o;
    logic [31:0] readDataM_o;
    logic        done_o;
    logic        misaligned_o;
    logic        timeout_o;

    memory_access_unit_if mem_bus ();

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_read  = '0;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        timeout;
        int          reqs;
        int          stalls;
    } exp_t;

    exp_t sb[$];

    memory_access_unit #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .resultSRCE_i (resultSRCE_i),
        .memWriteE_i  (memWriteE_i),
        .ALUresultE_i (ALUresultE_i),
        .RD2E_i       (RD2E_i),
        .memTypeE_i   (memTypeE_i),
        .memSignE_i   (memSignE_i),
        .mem          (mem_bus.master),
        .stall_o      (stall_o),
        .readDataM_o  (readDataM_o),
        .done_o       (done_o),
        .misaligned_o (misaligned_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        resultSRCE_i = 1'b0;
        memWriteE_i  = 1'b0;
        ALUresultE_i = '0;
        RD2E_i       = '0;
        memTypeE_i   = 2'b00;
        memSignE_i   = 1'b0;
    endtask

    // Called just after a rising edge; returns just after a rising edge with the unit idle.
    // ready_at < 0 means the memory never answers.
    task automatic apply_stimulus(input string tag, input logic ld, input logic st,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] typ, input logic sgn,
                                  input int ready_at, input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] raw;
        int          sh;
        int          req_n    = 0;
        int          stall_n  = 0;
        bit          finished = 0;

        e.tag     = tag;
        e.we      = st;
        e.addr    = a & 32'hFFFF_FFFC;
        e.timeout = (ready_at < 0) || (ready_at >= TIMEOUT);
        e.reqs    = e.timeout ? TIMEOUT : ready_at + 1;
        e.stalls  = e.reqs + 1;
        e.wdata   = '0;
        e.wstrb   = 4'b0000;
        if (st) begin
            case (typ)
                2'b00: begin
                    e.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
                    e.wstrb = 4'(1 << a[1:0]);
                end
                2'b01: begin
                    e.wdata = (d & 32'h0000_FFFF) * 32'h0001_0001;
                    e.wstrb = a[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    e.wdata = d;
                    e.wstrb = 4'b1111;
                end
            endcase
        end else if (e.timeout) begin
            model_read = '0;
        end else begin
            case (typ)
                2'b00: begin
                    sh  = int'(a[1:0]) * 8;
                    raw = (rdata >> sh) & 32'h0000_00FF;
                    if (sgn && raw[7]) raw = raw | 32'hFFFF_FF00;
                end
                2'b01: begin
                    sh  = a[1] ? 16 : 0;
                    raw = (rdata >> sh) & 32'h0000_FFFF;
                    if (sgn && raw[15]) raw = raw | 32'hFFFF_0000;
                end
                default: raw = rdata;
            endcase
            model_read = raw;
        end
        e.rdata = model_read;
        sb.push_back(e);

        resultSRCE_i = ld;
        memWriteE_i  = st;
        ALUresultE_i = a;
        RD2E_i       = d;
        memTypeE_i   = typ;
        memSignE_i   = sgn;

        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clk);
            if (stall_o) stall_n++;
            if (mem_bus.mem_req_o) begin
                check_output({tag, " addr"}, mem_bus.mem_addr_o, sb[0].addr);
                check_output({tag, " we"}, 32'(mem_bus.mem_we_o), 32'(sb[0].we));
                check_output({tag, " wstrb"}, 32'(mem_bus.mem_wstrb_o), 32'(sb[0].wstrb));
                if (sb[0].we) check_output({tag, " wdata"}, mem_bus.mem_wdata_o, sb[0].wdata);
                if (req_n == ready_at) begin
                    mem_bus.mem_ready_i = 1'b1;
                    mem_bus.mem_rdata_i = rdata;
                end
                req_n++;
            end
            if (done_o) begin
                e = sb.pop_front();
                check_output({e.tag, " readData"}, readDataM_o, e.rdata);
                check_output({e.tag, " timeout"}, 32'(timeout_o), 32'(e.timeout));
                check_output({e.tag, " stalls"}, 32'(stall_n), 32'(e.stalls));
                check_output({e.tag, " reqs"}, 32'(req_n), 32'(e.reqs));
                finished = 1;
            end
            @(posedge clk);
            #1;
            mem_bus.mem_ready_i = 1'b0;
            mem_bus.mem_rdata_i = $urandom;
        end

        if (!finished) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s done_o never seen within 40 cycles", tag);
            void'(sb.pop_front());
        end

        clear_inputs();
        @(negedge clk);
        check_output({tag, " done pulse end"}, 32'(done_o), 32'd0);
        check_output({tag, " timeout pulse end"}, 32'(timeout_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_misaligned(input string tag, input logic [31:0] a, input logic [1:0] typ);
        resultSRCE_i = 1'b1;
        ALUresultE_i = a;
        memTypeE_i   = typ;
        @(negedge clk);
        check_output({tag, " misaligned"}, 32'(misaligned_o), 32'd1);
        check_output({tag, " stall"}, 32'(stall_o), 32'd0);
        check_output({tag, " req"}, 32'(mem_bus.mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_output({tag, " req after"}, 32'(mem_bus.mem_req_o), 32'd0);
            check_output({tag, " misaligned after"}, 32'(misaligned_o), 32'd0);
        end
        check_output({tag, " readData held"}, readDataM_o, model_read);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        clear_inputs();
        mem_bus.mem_ready_i = 1'b0;
        mem_bus.mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset req", 32'(mem_bus.mem_req_o), 32'd0);
        check_output("reset stall", 32'(stall_o), 32'd0);
        check_output("reset done", 32'(done_o), 32'd0);
        check_output("reset readData", readDataM_o, 32'd0);
        check_output("reset wstrb", 32'(mem_bus.mem_wstrb_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] stores");
        apply_stimulus("sw", 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 32'h0);
        apply_stimulus("sb", 1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 2'b00, 1'b0, 0, 32'h0);
        apply_stimulus("sh", 1'b0, 1'b1, 32'h0000_0102, 32'h1234_BEEF, 2'b01, 1'b0, 1, 32'h0);

        $display("[TB] loads");
        apply_stimulus("lb", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b00, 1'b1, 0, 32'h1280_FF00);
        apply_stimulus("lbu", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b00, 1'b0, 0, 32'h1280_FF00);
        apply_stimulus("lhu", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b0, 0, 32'h1280_FF00);
        apply_stimulus("ld+st", 1'b1, 1'b1, 32'h0000_0101, 32'h0000_007E, 2'b00, 1'b0, 0, 32'h5555_5555);
        apply_stimulus("lh slow", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b01, 1'b1, 2, 32'h0000_F234);

        $display("[TB] misaligned");
        apply_misaligned("lh mis", 32'h0000_0101, 2'b01);
        apply_misaligned("lw mis", 32'h0000_0102, 2'b10);
        apply_misaligned("l11 mis", 32'h0000_0101, 2'b11);

        $display("[TB] timeout");
        apply_stimulus("lw tmo", 1'b1, 1'b0, 32'h0000_0108, 32'h0, 2'b10, 1'b0, -1, 32'h0);
        apply_stimulus("lw late", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 2'b11, 1'b0, TIMEOUT - 1, 32'hCAFE_F00D);

        $display("[TB] reset mid-request");
        resultSRCE_i = 1'b1;
        ALUresultE_i = 32'h0000_0200;
        memTypeE_i   = 2'b10;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rst req1", 32'(mem_bus.mem_req_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_read = '0;
        @(negedge clk);
        check_output("rst req", 32'(mem_bus.mem_req_o), 32'd0);
        check_output("rst stall", 32'(stall_o), 32'd0);
        check_output("rst done", 32'(done_o), 32'd0);
        check_output("rst timeout", 32'(timeout_o), 32'd0);
        check_output("rst misaligned", 32'(misaligned_o), 32'd0);
        check_output("rst readData", readDataM_o, 32'd0);
        check_output("rst we", 32'(mem_bus.mem_we_o), 32'd0);
        check_output("rst addr", mem_bus.mem_addr_o, 32'd0);
        check_output("rst wdata", mem_bus.mem_wdata_o, 32'd0);
        check_output("rst wstrb", 32'(mem_bus.mem_wstrb_o), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus("lw post", 1'b1, 1'b0, 32'h0000_0204, 32'h0, 2'b10, 1'b0, 0, 32'h0BAD_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
